// File: rtl/iir_pkg.sv
// Shared fixed-point constants and Q-format helpers for the IIR filter chain.
package iir_pkg;

  localparam int NDINT_DEF  = 3;
  localparam int NDFRAC_DEF = 22;
  localparam int NOUT_DEF   = 16;
  localparam int NDEPTH_DEF = 8;

  localparam int DIN_W_DEF  = NDINT_DEF + NDFRAC_DEF;

  function automatic int din_width(input int ndint, input int ndfrac);
    return ndint + ndfrac;
  endfunction

  // Bit position of the round-half-up constant, in input LSBs.
  function automatic int round_pos(input int ndfrac, input int nout);
    return ndfrac - nout;
  endfunction

  function automatic int drop_bits(input int ndfrac, input int nout);
    return ndfrac - (nout - 1);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iir_decimator_if.sv
// Valid/ready output stream carrying decimated Q1.(data_w-1) samples.
interface iir_decimator_if
  import iir_pkg::*;
#(
  parameter int data_w = NOUT_DEF
);

  logic              m_valid;
  logic              m_ready;
  logic [data_w-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational read port; writes to a full FIFO are
// dropped unless a read happens in the same cycle.
module sync_fifo
  import iir_pkg::*;
#(
  parameter int width = NOUT_DEF,
  parameter int depth = NDEPTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_valid,
  input  logic [width-1:0] wr_data,
  output logic             wr_drop,
  iir_decimator_if.master  rd_bus
);

  localparam int AW = $clog2(depth);
  localparam int CW = cnt_width(depth);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, wr_en, rd_en;

  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    rd_en    = rd_bus.m_ready && !empty;
    wr_en    = wr_valid && (!full || rd_en);
    wr_drop  = wr_valid && full && !rd_en;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_bus.m_valid = !empty;
  assign rd_bus.m_data  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/iir_decimator.sv
// Decimates the IIR filter output stream by a runtime ratio, rounds and
// saturates each kept sample to Q1.(Nout-1) and buffers it for the consumer.
module iir_decimator
  import iir_pkg::*;
#(
  parameter int Ndint  = NDINT_DEF,
  parameter int Ndfrac = NDFRAC_DEF,
  parameter int Nout   = NOUT_DEF,
  parameter int Ndepth = NDEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    dv_in,
  input  logic [Ndint+Ndfrac-1:0] d_in,
  input  logic [7:0]              decim,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [Nout-1:0]         m_data,
  output logic                    ovf,
  input  logic                    clr_ovf
);

  localparam int DW    = din_width(Ndint, Ndfrac);
  localparam int RND   = round_pos(Ndfrac, Nout);
  localparam int SHIFT = drop_bits(Ndfrac, Nout);
  localparam int RW    = DW + 1 - SHIFT;

  localparam logic [DW:0]     RND_ADD = {{DW{1'b0}}, 1'b1} << RND;
  localparam logic [Nout-1:0] SAT_MAX = {1'b0, {(Nout-1){1'b1}}};
  localparam logic [Nout-1:0] SAT_MIN = {1'b1, {(Nout-1){1'b0}}};

  logic [7:0]      phase_q, phase_d;
  logic [7:0]      ratio_q, ratio_d;
  logic [7:0]      new_ratio;
  logic            select;
  logic            pipe_vld_q, pipe_vld_d;
  logic [Nout-1:0] pipe_data_q, pipe_data_d;
  logic            ovf_q, ovf_d;
  logic            fifo_drop;
  logic [DW:0]     sum;
  logic [RW-1:0]   rounded;
  logic [Nout-1:0] sat;

  iir_decimator_if #(.data_w(Nout)) m_bus ();

  // One guard bit above the sign keeps the round-half-up add from wrapping.
  always_comb begin
    sum     = {d_in[DW-1], d_in} + RND_ADD;
    rounded = RW'(sum >> SHIFT);
    if ((&rounded[RW-1:Nout-1]) || !(|rounded[RW-1:Nout-1])) begin
      sat = rounded[Nout-1:0];
    end else if (rounded[RW-1]) begin
      sat = SAT_MIN;
    end else begin
      sat = SAT_MAX;
    end
  end

  // The ratio is latched only on a kept sample, so mid-period changes
  // wait for the next wrap.
  always_comb begin
    phase_d   = phase_q;
    ratio_d   = ratio_q;
    select    = 1'b0;
    new_ratio = (decim == 8'd0) ? 8'd1 : decim;
    if (dv_in) begin
      if (phase_q == 8'd0) begin
        select  = 1'b1;
        ratio_d = new_ratio;
        phase_d = (new_ratio == 8'd1) ? 8'd0 : 8'd1;
      end else if (phase_q == ratio_q - 8'd1) begin
        phase_d = 8'd0;
      end else begin
        phase_d = phase_q + 8'd1;
      end
    end
    pipe_vld_d  = select;
    pipe_data_d = select ? sat : pipe_data_q;
    ovf_d       = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q     <= 8'd0;
      ratio_q     <= 8'd1;
      pipe_vld_q  <= 1'b0;
      pipe_data_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      ratio_q     <= ratio_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo #(
    .width (Nout),
    .depth (Ndepth)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .wr_valid (pipe_vld_q),
    .wr_data  (pipe_data_q),
    .wr_drop  (fifo_drop),
    .rd_bus   (m_bus)
  );

  assign m_bus.m_ready = m_ready;
  assign m_valid       = m_bus.m_valid;
  assign m_data        = m_bus.m_data;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_iir_decimator.sv
// Scoreboard bench for iir_decimator: expected samples are queued as stimulus
// is driven and checked by a monitor whenever the consumer takes a sample.
module tb_iir_decimator;

  logic        clk;
  logic        resetn;
  logic        dv_in;
  logic [24:0] d_in;
  logic [7:0]  decim;
  logic        clr_ovf;
  logic        ovf;

  iir_decimator_if #(.data_w(16)) bus_if ();

  iir_decimator #(
    .Ndint  (3),
    .Ndfrac (22),
    .Nout   (16),
    .Ndepth (8)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .dv_in   (dv_in),
    .d_in    (d_in),
    .decim   (decim),
    .m_valid (bus_if.m_valid),
    .m_ready (bus_if.m_ready),
    .m_data  (bus_if.m_data),
    .ovf     (ovf),
    .clr_ovf (clr_ovf)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_out   = 0;
  int          mphase  = 0;
  int          mratio  = 1;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: floor((x + 64) / 128), clamped to 16-bit signed.
  function automatic logic [15:0] model(input logic [24:0] d);
    longint v;
    longint r;
    v = longint'($signed(d));
    r = (v + 64) >>> 7;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus_if.m_valid === 1'b1 && bus_if.m_ready === 1'b1) begin
      n_tests++;
      n_out++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_output: got %h, required no output", bus_if.m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus_if.m_data !== mon_exp) begin
          n_fail++;
          $display("[TB] FAIL sample_data: got %h, required %h", bus_if.m_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [24:0] d, input bit keep);
    int r;
    dv_in = 1'b1;
    d_in  = d;
    if (mphase == 0) begin
      r      = (decim == 8'd0) ? 1 : int'(decim);
      mratio = r;
      if (keep) exp_q.push_back(model(d));
      mphase = (r == 1) ? 0 : 1;
    end else begin
      mphase = (mphase == mratio - 1) ? 0 : mphase + 1;
    end
    tick();
    dv_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL %s_drain: %0d samples still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    dv_in          = 1'b0;
    d_in           = '0;
    decim          = 8'd1;
    clr_ovf        = 1'b0;
    bus_if.m_ready = 1'b1;
    #3;
    n_tests += 3;
    if (bus_if.m_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_m_valid: got %b, required 0", bus_if.m_valid);
    end
    if (bus_if.m_data !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_m_data: got %h, required 0000", bus_if.m_data);
    end
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ovf: got %b, required 0", ovf);
    end
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    decim = 8'd1;
    send_sample(25'h0200000, 1'b1);
    n_tests++;
    if (bus_if.m_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL latency_t1: m_valid got %b, required 0", bus_if.m_valid);
    end
    tick();
    n_tests++;
    if (bus_if.m_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL latency_t2: m_valid got %b, required 1", bus_if.m_valid);
    end
    wait_drain(10, "latency");
  endtask

  task automatic test_rounding();
    logic [24:0] din_tab [7];
    logic [15:0] exp_tab [7];
    din_tab = '{25'h0200000, 25'h0000040, 25'h000003F, 25'h1FFFFC0,
                25'h0600000, 25'h1000000, 25'h0FFFFFF};
    exp_tab = '{16'h4000, 16'h0001, 16'h0000, 16'h0000,
                16'h7FFF, 16'h8000, 16'h7FFF};
    decim = 8'd1;
    bus_if.m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(exp_tab[i]);
      send_sample(din_tab[i], 1'b0);
    end
    wait_drain(20, "rounding");
  endtask

  task automatic test_decimation();
    int start;
    start = n_out;
    decim = 8'd4;
    for (int i = 0; i < 12; i++) begin
      send_sample(25'(i * 32'h11000), 1'b1);
      tick();
    end
    wait_drain(20, "decim4");
    tick();
    n_tests++;
    if (n_out - start != 3) begin
      n_fail++;
      $display("[TB] FAIL decim4_count: got %0d outputs, required 3", n_out - start);
    end
  endtask

  task automatic test_decim_change();
    int start;
    start = n_out;
    decim = 8'd3;
    send_sample(25'h0010000, 1'b1);
    decim = 8'd2;
    for (int i = 1; i < 8; i++) begin
      send_sample(25'(32'h0010000 + i * 32'h3000), 1'b1);
    end
    decim = 8'd0;
    for (int i = 0; i < 3; i++) begin
      send_sample(25'(32'h1F00000 + i * 32'h777), 1'b1);
    end
    wait_drain(20, "decim_change");
    tick();
    n_tests++;
    if (n_out - start != 6) begin
      n_fail++;
      $display("[TB] FAIL decim_change_count: got %0d outputs, required 6", n_out - start);
    end
  endtask

  task automatic test_overflow();
    int start;
    decim = 8'd1;
    bus_if.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_sample(25'(32'h0004000 + i * 32'h2480), i < 8);
    end
    tick();
    tick();
    n_tests += 3;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overflow_ovf: got %b, required 1", ovf);
    end
    if (bus_if.m_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overflow_valid: got %b, required 1", bus_if.m_valid);
    end
    if (bus_if.m_data !== exp_q[0]) begin
      n_fail++;
      $display("[TB] FAIL stall_hold_a: got %h, required %h", bus_if.m_data, exp_q[0]);
    end
    tick();
    tick();
    n_tests++;
    if (bus_if.m_data !== exp_q[0]) begin
      n_fail++;
      $display("[TB] FAIL stall_hold_b: got %h, required %h", bus_if.m_data, exp_q[0]);
    end
    send_sample(25'h0123456, 1'b0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ovf_set_priority: got %b, required 1", ovf);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ovf_clear: got %b, required 0", ovf);
    end
    start = n_out;
    bus_if.m_ready = 1'b1;
    wait_drain(20, "overflow");
    tick();
    n_tests += 2;
    if (n_out - start != 8) begin
      n_fail++;
      $display("[TB] FAIL overflow_count: got %0d outputs, required 8", n_out - start);
    end
    if (bus_if.m_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL overflow_empty: m_valid got %b, required 0", bus_if.m_valid);
    end
  endtask

  task automatic test_full_rw();
    int start;
    start = n_out;
    decim = 8'd1;
    bus_if.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_sample(25'(32'h1E00000 + i * 32'h1357), 1'b1);
    end
    tick();
    tick();
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_baseline_ovf: got %b, required 0", ovf);
    end
    send_sample(25'h00ABCDE, 1'b1);
    bus_if.m_ready = 1'b1;
    tick();
    bus_if.m_ready = 1'b0;
    tick();
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_rw_ovf: got %b, required 0", ovf);
    end
    bus_if.m_ready = 1'b1;
    wait_drain(20, "full_rw");
    tick();
    n_tests++;
    if (n_out - start != 9) begin
      n_fail++;
      $display("[TB] FAIL full_rw_count: got %0d outputs, required 9", n_out - start);
    end
  endtask

  task automatic test_reset_flush();
    int start;
    bus_if.m_ready = 1'b0;
    decim = 8'd1;
    send_sample(25'h0011111, 1'b1);
    send_sample(25'h0022222, 1'b1);
    decim = 8'd4;
    send_sample(25'h0033333, 1'b1);
    send_sample(25'h0044444, 1'b1);
    tick();
    tick();
    n_tests++;
    if (bus_if.m_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush_queued: m_valid got %b, required 1", bus_if.m_valid);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_tests += 2;
    if (bus_if.m_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_m_valid: got %b, required 0", bus_if.m_valid);
    end
    if (bus_if.m_data !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL flush_m_data: got %h, required 0000", bus_if.m_data);
    end
    exp_q.delete();
    mphase = 0;
    mratio = 1;
    tick();
    resetn = 1'b1;
    tick();
    start = n_out;
    bus_if.m_ready = 1'b1;
    send_sample(25'h0055555, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send_sample(25'(32'h0066666 + i), 1'b1);
    end
    wait_drain(20, "flush");
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (n_out - start != 1) begin
      n_fail++;
      $display("[TB] FAIL flush_count: got %0d outputs, required 1", n_out - start);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_decimation();
    test_decim_change();
    test_overflow();
    test_full_rw();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/iir_decimator.md
IIR_DECIMATOR -- requirements
Module: iir_decimator

Interface
REQ-001 SHALL have parameter Ndint, default 3, meaning integer bits of the signed input sample, sign bit included.
REQ-002 SHALL have parameter Ndfrac, default 22, meaning fractional bits of the input sample.
REQ-003 SHALL have parameter Nout, default 16, meaning signed output width in Q1.(Nout-1) format.
REQ-004 SHALL have parameter Ndepth, default 8, meaning output FIFO depth; it must be a power of 2 and at least 2.
REQ-005 SHALL have ports in this order: clk input 1, the single clock.
REQ-006 SHALL have port resetn input 1; reset is asynchronous and active-low.
REQ-007 SHALL have port dv_in input 1: input sample valid, one cycle per sample, from the iir_filter dv_out.
REQ-008 SHALL have port d_in input Ndint+Ndfrac: signed fixed-point sample, from the iir_filter d_out.
REQ-009 SHALL have port decim input 8: decimation ratio; 0 is treated as 1.
REQ-010 SHALL have port m_valid output 1: an output sample is available.
REQ-011 SHALL have port m_ready input 1: the consumer accepts the sample.
REQ-012 SHALL have port m_data output Nout: the rounded and saturated sample.
REQ-013 SHALL have port ovf output 1: sticky flag, set when a sample is dropped because the FIFO is full.
REQ-014 SHALL have port clr_ovf input 1: synchronous clear of ovf.

Function
REQ-015 SHALL keep a phase counter that counts dv_in pulses: 0..R-1, where R = max(decim, 1).
REQ-016 SHALL select a sample when dv_in=1 and phase==0; the counter then wraps from R-1 to 0.
REQ-017 SHALL sample decim only when phase==0 and dv_in=1; a change made mid-period takes effect at the next wrap.
REQ-018 SHALL round a selected sample by adding 2^(Ndfrac-Nout) in input LSBs (round half up) and dropping the lowest Ndfrac-(Nout-1) bits.
REQ-019 SHALL perform the rounding add with at least one guard bit so the add cannot wrap.
REQ-020 SHALL saturate the rounded value to [-2^(Nout-1), 2^(Nout-1)-1].
REQ-021 SHALL register the rounded and saturated result once, then write it into the FIFO.
REQ-022 SHALL have a latency of 2 cycles: a selected sample at cycle t appears on m_valid/m_data at t+2 when the FIFO is empty.
REQ-023 SHALL transfer a sample on a cycle with m_valid and m_ready both 1; m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-024 SHALL allow a write and a read in the same cycle when the FIFO is full; the write is accepted and no sample is dropped.
REQ-025 SHALL, on a write to a full FIFO with no simultaneous read, drop the new sample, keep the FIFO contents unchanged and set ovf.
REQ-026 SHALL give set priority over clear: if clr_ovf and a drop occur in the same cycle, ovf=1.
REQ-027 SHALL wrap the FIFO pointers modulo Ndepth and derive full/empty from a count of width log2(Ndepth)+1.
REQ-028 SHALL ignore dv_in=1 with phase!=0 apart from advancing the counter.

Reset
REQ-029 SHALL, on resetn low, immediately set: phase=0, FIFO empty, m_valid=0, m_data=0, ovf=0, pipeline valid=0.
REQ-030 SHALL discard on reset any sample in flight in the pipeline register or the FIFO.
REQ-031 SHALL, after resetn deasserts, select the first dv_in sample as an output.

Structure
REQ-032 SHALL take the fixed-point width constants and the Q-format helper parameters from a shared package, iir_pkg.
REQ-033 SHALL use the parameter-derived width localparams of the shared package iir_pkg.
REQ-034 SHALL implement the FIFO as one sub-module, sync_fifo (parameters width and depth; async active-low reset).
REQ-035 SHALL implement the phase counter, rounding and saturation in the top level.

Verification
REQ-036 SHALL cover: decim=4, 12 dv_in pulses, m_ready=1 -> exactly 3 outputs, taken from input samples 0, 4 and 8.
REQ-037 SHALL cover: decim=1, d_in=0x0200000 (0.5) -> m_data=0x4000; d_in=0x0000040 -> 0x0001; d_in=0x000003F -> 0x0000; d_in=-0x40 -> 0x0000.
REQ-038 SHALL cover: d_in=0x0600000 (+1.5) -> 0x7FFF; d_in=0x1000000 (-4.0) -> 0x8000; d_in=0x00FFFFFF (max) -> 0x7FFF.
REQ-039 SHALL cover: m_ready=0, decim=1, 10 samples with Ndepth=8 -> 8 stored, ovf=1, drained order matches the first 8; clr_ovf then gives ovf=0.
REQ-040 SHALL cover: FIFO full, m_ready=1 and a new sample in the same cycle -> no drop, ovf stays 0.
REQ-041 SHALL cover: resetn pulsed low with 3 samples queued and phase=2 -> m_valid=0 at once; the next dv_in sample is output.
